freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, meaning system clock frequency in MHz.
REQ-002 SHALL have parameter FREQ_MID_KHZ, default 200, meaning the nominal mid-band frequency in kHz.
REQ-003 SHALL have parameter GEN_PARAMETER, default 255, meaning the maximum frequency code; the code width is the width of GEN_PARAMETER.
REQ-004 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive in-range half-periods required to assert lock.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sig, input, 1 bit: the measured square wave, asynchronous to clk.
REQ-008 SHALL have port half_cnt, output, HW bits: the last measured half-period in clk cycles.
REQ-009 SHALL have port code, output, code width: the frequency code corresponding to half_cnt.
REQ-010 SHALL have port valid, output, 1 bit: a one-cycle pulse marking that half_cnt and code were updated.
REQ-011 SHALL have port under / over, outputs, 1 bit each: code was saturated low / high.
REQ-012 SHALL have port locked, output, 1 bit: the measurement is stable.
REQ-013 SHALL have port timeout, output, 1 bit: no sig edge has occurred within T_MAX cycles.

Function
REQ-014 SHALL use CNT_MID = (500*CLK_MHZ)/FREQ_MID_KHZ - GEN_PARAMETER/2, with integer division; defaults give CNT_MID = 123.
REQ-015 SHALL use T_MAX = 2*(CNT_MID+GEN_PARAMETER) cycles; HW = clog2(T_MAX+1).
REQ-016 SHALL pass sig through a 2-flop synchronizer and then an edge detector; both rising and falling edges count as events.
REQ-017 SHALL implement the state machine IDLE -> ARMED -> MEASURE, with TIMEOUT reachable from ARMED or MEASURE.
REQ-018 In IDLE (entered after reset), the first edge SHALL transition to ARMED and clear the period counter to 1.
REQ-019 In ARMED, the counter SHALL increment each cycle; the next edge SHALL transition to MEASURE and publish the first measurement.
REQ-020 On each edge in ARMED or MEASURE, the block SHALL latch half_cnt = counter value, set the counter to 1, and pulse valid for 1 cycle on the cycle after the edge-detect cycle.
REQ-021 SHALL compute the code as half_cnt - CNT_MID, saturating to 0 with under=1 if half_cnt < CNT_MID, and to GEN_PARAMETER with over=1 if the difference exceeds GEN_PARAMETER.
REQ-022 under, over and code SHALL update only together with valid.
REQ-023 When the counter reaches T_MAX without an edge, the block SHALL enter TIMEOUT: timeout=1, locked=0, counter held; half_cnt and code are retained.
REQ-024 An edge in TIMEOUT SHALL clear timeout and transition to ARMED exactly as from IDLE, with no valid pulse.
REQ-025 Lock counter behaviour SHALL be: a valid pulse with under=0, over=0, and |half_cnt - previous half_cnt| <= 1 increments the lock counter (saturating); any other valid pulse clears it to 0.
REQ-026 locked SHALL be 1 while the lock counter >= LOCK_CNT.
REQ-027 Counter arithmetic SHALL never wrap; the counter saturates at T_MAX.
REQ-028 An edge arriving on the same cycle the counter hits T_MAX SHALL be treated as an edge (measurement published, no timeout).

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0 and the state SHALL be IDLE.
REQ-030 Synchronizer flops, the counter, the lock counter and the previous-half register SHALL clear on reset.
REQ-031 Reset asserted mid-measurement SHALL abort the measurement with no valid pulse; after release, the block requires two edges before the first valid.

Structure
REQ-032 CNT_MID, T_MAX, HW and the state enum SHALL reside in the shared package freq_pkg, which ref_gen also uses for CNT_MID.
REQ-033 The synchronizer and edge detector SHALL be the sub-module sync_edge (inputs clk, rst_n, async in; outputs rise, fall, any).

Verification
REQ-034 A ref_gen instance with inp=0 drives sig -> after 2 edges, valid pulses with half_cnt=123, code=0, under=0, over=0; locked=1 after the 4th further valid.
REQ-035 A ref_gen instance with inp=255 -> half_cnt=378, code=255, over=0; with inp=100 -> half_cnt=223, code=100.
REQ-036 sig with half-period 100 cycles -> code=0, under=1, locked stays 0; half-period 500 -> code=255, over=1.
REQ-037 sig held constant after lock -> timeout=1 exactly 756 cycles after the last edge, locked=0; the next edge gives no valid, and the following edge gives valid.
REQ-038 rst_n pulsed low for 3 cycles mid-half-period -> all outputs 0 immediately (asynchronous); the first valid occurs on the 2nd edge after release.
REQ-039 Alternating half-periods 200 and 202 -> lock counter clears every valid, so locked stays 0.

Source files
------------

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared constants, derivation helpers and FSM states for the frequency meter
package freq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE,
    ST_TIMEOUT
  } state_t;

  function automatic int calc_cnt_mid(input int clk_mhz, input int freq_khz, input int gen);
    return (500 * clk_mhz) / freq_khz - gen / 2;
  endfunction

  function automatic int calc_t_max(input int clk_mhz, input int freq_khz, input int gen);
    return 2 * (calc_cnt_mid(clk_mhz, freq_khz, gen) + gen);
  endfunction

  function automatic int calc_hw(input int clk_mhz, input int freq_khz, input int gen);
    return $clog2(calc_t_max(clk_mhz, freq_khz, gen) + 1);
  endfunction

  localparam int CNT_MID = calc_cnt_mid(100, 200, 255);
  localparam int T_MAX   = calc_t_max(100, 200, 255);
  localparam int HW      = calc_hw(100, 200, 255);

endpackage

// File: rtl/ref_gen.sv
// rtl/ref_gen.sv - square-wave source whose half-period is CNT_MID + inp clock cycles
module ref_gen
  import freq_pkg::*;
#(
  parameter int CLK_MHZ       = 100,
  parameter int FREQ_MID_KHZ  = 200,
  parameter int GEN_PARAMETER = 255,
  localparam int CW_P = $clog2(GEN_PARAMETER + 1),
  localparam int HW_P = calc_hw(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CW_P-1:0] inp,
  output logic            sig
);

  localparam logic [HW_P-1:0] CNT_MID_V = HW_P'(calc_cnt_mid(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER));

  logic [HW_P-1:0] r_cnt;
  logic            r_sig;
  logic [HW_P-1:0] w_last;

  assign w_last = CNT_MID_V + HW_P'(inp) - HW_P'(1);

  // >= rather than == so a lowered inp mid-half-period cannot strand the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sig <= 1'b0;
    end else if (r_cnt >= w_last) begin
      r_cnt <= '0;
      r_sig <= ~r_sig;
    end else begin
      r_cnt <= r_cnt + HW_P'(1);
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer followed by rise/fall edge detection
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall,
  output logic any
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;
  assign fall = ~r_sync & r_prev;
  assign any  = r_sync ^ r_prev;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - half-period meter producing a saturated frequency code, lock and timeout flags
module freq_meter
  import freq_pkg::*;
#(
  parameter int CLK_MHZ       = 100,
  parameter int FREQ_MID_KHZ  = 200,
  parameter int GEN_PARAMETER = 255,
  parameter int LOCK_CNT      = 4,
  localparam int HW_P = calc_hw(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER),
  localparam int CW_P = $clog2(GEN_PARAMETER + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sig,
  output logic [HW_P-1:0] half_cnt,
  output logic [CW_P-1:0] code,
  output logic            valid,
  output logic            under,
  output logic            over,
  output logic            locked,
  output logic            timeout
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [HW_P-1:0] CNT_MID_V = HW_P'(calc_cnt_mid(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER));
  localparam logic [HW_P-1:0] T_MAX_V   = HW_P'(calc_t_max(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER));
  localparam logic [HW_P-1:0] GEN_V     = HW_P'(GEN_PARAMETER);
  localparam logic [HW_P-1:0] ONE_V     = HW_P'(1);
  localparam logic [LW-1:0]   LOCK_V    = LW'(LOCK_CNT);

  state_t          r_state;
  state_t          w_next;
  logic [HW_P-1:0] r_cnt;
  logic [HW_P-1:0] r_half;
  logic [CW_P-1:0] r_code;
  logic            r_valid;
  logic            r_under;
  logic            r_over;
  logic [LW-1:0]   r_lock;

  logic            w_rise;
  logic            w_fall;
  logic            w_any;
  logic            w_unused_dir;
  logic            w_edge;
  logic            w_arm;
  logic            w_publish;
  logic            w_to;
  logic            w_counting;
  logic [HW_P-1:0] w_diff;
  logic            w_under_n;
  logic            w_over_n;
  logic [CW_P-1:0] w_code_n;
  logic            w_close;

  sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig),
    .rise     (w_rise),
    .fall     (w_fall),
    .any      (w_any)
  );

  assign w_unused_dir = w_rise & w_fall;
  assign w_edge       = w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // An edge outranks the T_MAX check, so an edge on the saturating cycle still publishes
  always_comb begin
    w_next    = r_state;
    w_arm     = 1'b0;
    w_publish = 1'b0;
    w_to      = 1'b0;
    case (r_state)
      ST_IDLE, ST_TIMEOUT: begin
        if (w_edge) begin
          w_next = ST_ARMED;
          w_arm  = 1'b1;
        end
      end
      ST_ARMED, ST_MEASURE: begin
        if (w_edge) begin
          w_next    = ST_MEASURE;
          w_publish = 1'b1;
        end else if (r_cnt == T_MAX_V) begin
          w_next = ST_TIMEOUT;
          w_to   = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_counting = (r_state == ST_ARMED) || (r_state == ST_MEASURE);
  assign w_under_n  = r_cnt < CNT_MID_V;
  assign w_diff     = r_cnt - CNT_MID_V;
  assign w_over_n   = !w_under_n && (w_diff > GEN_V);
  assign w_code_n   = w_under_n ? '0 : (w_over_n ? CW_P'(GEN_PARAMETER) : w_diff[CW_P-1:0]);
  assign w_close    = (r_cnt >= r_half) ? ((r_cnt - r_half) <= ONE_V) : ((r_half - r_cnt) <= ONE_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_half  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_under <= 1'b0;
      r_over  <= 1'b0;
      r_lock  <= '0;
    end else begin
      r_valid <= w_publish;
      if (w_arm || w_publish) begin
        r_cnt <= ONE_V;
      end else if (w_counting && (r_cnt != T_MAX_V)) begin
        r_cnt <= r_cnt + ONE_V;
      end
      if (w_publish) begin
        r_half  <= r_cnt;
        r_code  <= w_code_n;
        r_under <= w_under_n;
        r_over  <= w_over_n;
        if (!w_under_n && !w_over_n && w_close) begin
          r_lock <= (r_lock == LOCK_V) ? r_lock : r_lock + LW'(1);
        end else begin
          r_lock <= '0;
        end
      end else if (w_to) begin
        // a dead input means stability must be re-earned from scratch
        r_lock <= '0;
      end
    end
  end

  assign half_cnt = r_half;
  assign code     = r_code;
  assign valid    = r_valid;
  assign under    = r_under;
  assign over     = r_over;
  assign locked   = (r_lock >= LOCK_V);
  assign timeout  = (r_state == ST_TIMEOUT);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;
  import freq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gen_rst_n = 1'b0;
  logic       use_ref = 1'b1;
  logic       tb_sig = 1'b0;
  logic [7:0] inp = 8'd0;
  logic       w_ref_sig;
  logic       sig;

  logic [9:0] half_cnt;
  logic [7:0] code;
  logic       valid, under, over, locked, timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] c_half, c_code, c_under, c_over;
  int          c_valids;
  logic        seen_locked, seen_timeout;

  always #5 clk = ~clk;
  assign sig = use_ref ? w_ref_sig : tb_sig;

  ref_gen u_gen (
    .clk   (clk),
    .rst_n (gen_rst_n),
    .inp   (inp),
    .sig   (w_ref_sig)
  );

  freq_meter u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig      (sig),
    .half_cnt (half_cnt),
    .code     (code),
    .valid    (valid),
    .under    (under),
    .over     (over),
    .locked   (locked),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid && k < budget);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  task automatic clr();
    c_valids     = 0;
    seen_locked  = 1'b0;
    seen_timeout = 1'b0;
  endtask

  // Waits n cycles capturing any valid pulse, then toggles sig.
  task automatic half(input int n);
    repeat (n) begin
      @(negedge clk);
      if (valid) begin
        c_valids++;
        c_half  = 32'(half_cnt);
        c_code  = 32'(code);
        c_under = 32'(under);
        c_over  = 32'(over);
      end
      seen_locked  = seen_locked | locked;
      seen_timeout = seen_timeout | timeout;
    end
    tb_sig = ~tb_sig;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic any_v;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_half", 32'(half_cnt), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_under", 32'(under), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    gen_rst_n = 1'b1;

    // mid-band reference: 123-cycle half periods
    wait_valid("ref0_first", 600);
    chk("ref0_half", 32'(half_cnt), 32'd123);
    chk("ref0_code", 32'(code), 32'd0);
    chk("ref0_under", 32'(under), 32'd0);
    chk("ref0_over", 32'(over), 32'd0);
    chk("ref0_lock0", 32'(locked), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      wait_valid("ref0_next", 300);
      chk("ref0_half_n", 32'(half_cnt), 32'd123);
      chk("ref0_lock_n", 32'(locked), (i == 4) ? 32'd1 : 32'd0);
    end

    inp = 8'd255;
    wait_valid("ref255_a", 900);
    chk("ref255_unlock", 32'(locked), 32'd0);
    wait_valid("ref255_b", 900);
    wait_valid("ref255_c", 900);
    chk("ref255_half", 32'(half_cnt), 32'd378);
    chk("ref255_code", 32'(code), 32'd255);
    chk("ref255_over", 32'(over), 32'd0);
    chk("ref255_under", 32'(under), 32'd0);

    inp = 8'd100;
    for (int i = 1; i <= 5; i++) begin
      wait_valid("ref100", 900);
      if (i >= 3) chk("ref100_lock", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("ref100_half", 32'(half_cnt), 32'd223);
    chk("ref100_code", 32'(code), 32'd100);

    // hold sig at its current level right after the last edge's valid
    tb_sig = w_ref_sig;
    use_ref = 1'b0;
    gen_rst_n = 1'b0;
    n = 0;
    any_v = 1'b0;
    while (!timeout && n < 1000) begin
      @(negedge clk);
      n++;
      any_v = any_v | valid;
    end
    chk("to_cycles", 32'(n), 32'd756);
    chk("to_locked", 32'(locked), 32'd0);
    chk("to_half_kept", 32'(half_cnt), 32'd223);
    chk("to_code_kept", 32'(code), 32'd100);
    chk("to_no_valid", 32'(any_v), 32'd0);

    clr();
    half(200);
    half(150);
    chk("to_cleared", 32'(timeout), 32'd0);
    chk("to_rearm_novalid", 32'(c_valids), 32'd0);
    wait_valid("to_resume", 20);
    chk("to_resume_half", 32'(half_cnt), 32'd150);
    chk("to_resume_code", 32'(code), 32'd27);

    clr();
    repeat (5) half(100);
    chk("under_nvalid", 32'(c_valids), 32'd4);
    chk("under_half", c_half, 32'd100);
    chk("under_code", c_code, 32'd0);
    chk("under_flag", c_under, 32'd1);
    chk("under_over", c_over, 32'd0);
    chk("under_nolock", 32'(seen_locked), 32'd0);

    clr();
    repeat (3) half(500);
    chk("over_nvalid", 32'(c_valids), 32'd3);
    chk("over_half", c_half, 32'd500);
    chk("over_code", c_code, 32'd255);
    chk("over_flag", c_over, 32'd1);
    chk("over_under", c_under, 32'd0);

    clr();
    for (int i = 0; i < 3; i++) begin
      half(200);
      half(202);
    end
    chk("alt_nolock", 32'(seen_locked), 32'd0);
    chk("alt_half", c_half, 32'd200);

    clr();
    repeat (6) half(200);
    chk("steady_lock", 32'(locked), 32'd1);
    chk("steady_half", c_half, 32'd200);

    // asynchronous reset in the middle of a half period
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_half", 32'(half_cnt), 32'd0);
    chk("arst_code", 32'(code), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_flags", 32'({under, over, timeout}), 32'd0);
    repeat (3) @(negedge clk);
    tb_sig = 1'b0;
    rst_n = 1'b1;
    clr();
    half(150);
    half(150);
    chk("arst_two_edges", 32'(c_valids), 32'd0);
    wait_valid("arst_first", 20);
    chk("arst_first_half", 32'(half_cnt), 32'd150);

    // edge landing exactly on T_MAX still measures
    half(100);
    clr();
    repeat (3) half(756);
    chk("tmax_no_timeout", 32'(seen_timeout), 32'd0);
    chk("tmax_half", c_half, 32'd756);
    chk("tmax_code", c_code, 32'd255);
    chk("tmax_over", c_over, 32'd1);

    // one cycle past T_MAX times out and the edge only re-arms
    clr();
    half(757);
    half(100);
    chk("tmax1_timeout", 32'(seen_timeout), 32'd1);
    chk("tmax1_nvalid", 32'(c_valids), 32'd1);
    wait_valid("tmax1_resume", 20);
    chk("tmax1_half", 32'(half_cnt), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
